// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Sequencer for the EX-stage multiply/divide unit and owner of the HI/LO
//   registers. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO and runs either a
//   MUL_LAT-cycle multiply or a 32-iteration restoring divide. While the unit
//   is working it stalls the pipeline. When the result is ready it commits
//   HI/LO once, unless the op is flushed first.
//
// Parameters
//   MUL_LAT   multiply latency after the start cycle (1..8)
//   HILO_RST  reset value of HI and LO
//
// Ports
//   clk, resetn    clock, asynchronous active-low reset
//   alucontrolE    EX-stage ALU op code
//   validE         EX slot holds a real instruction
//   srcaE, srcbE   rs / rt operands
//   flushE         kills any op in progress; no HI/LO write
//   stall_ext      pipeline frozen by another source; holds DONE and MT* writes
//   stall_md       freeze request while a mul/div is running
//   hi_o, lo_o     registered HI / LO
//   busy           FSM not idle
//
// Configuration
//   MULDIV_DIV0_FAST_EN  when defined, a divide by zero skips the iterations
//                        and goes straight to DONE with the same result values.

module muldiv_ctrl #(
  parameter int          MUL_LAT  = 2,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  alucontrolE,
  input  logic        validE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  input  logic        stall_ext,
  output logic        stall_md,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy
);

  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul_op, is_div_op, is_signed_op;
  logic        start, div0, mul_last, div_last, commit, mt_ok;
  logic [31:0] a_mag, b_mag;
  logic [32:0] div_diff;
  logic [63:0] mul_res;
  logic [31:0] div_hi, div_lo;

  assign is_mul_op    = (alucontrolE == EXE_MULT_OP) | (alucontrolE == EXE_MULTU_OP);
  assign is_div_op    = (alucontrolE == EXE_DIV_OP)  | (alucontrolE == EXE_DIVU_OP);
  assign is_signed_op = (alucontrolE == EXE_MULT_OP) | (alucontrolE == EXE_DIV_OP);
  assign start        = validE & ~flushE & (state_q == S_IDLE) & (is_mul_op | is_div_op);
  assign div0         = is_div_op & (srcbE == 32'h0);
  assign mul_last     = (cnt_q == 5'(MUL_LAT - 1));
  assign div_last     = (cnt_q == 5'd31);

  // Both datapaths work on operand magnitudes. The signs are reapplied when the result is committed.
  assign a_mag = (is_signed_op & srcaE[31]) ? -srcaE : srcaE;
  assign b_mag = (is_signed_op & srcbE[31]) ? -srcbE : srcbE;

  // Partial remainder shifted left by one, minus the divisor. Bit 32 is the borrow.
  assign div_diff = acc_q[63:31] - {1'b0, b_q};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = is_mul_op ? S_MUL : S_DIV;
`ifdef MULDIV_DIV0_FAST_EN
          if (div0) state_d = S_DONE;
`endif
        end
      end
      S_MUL:   if (mul_last) state_d = S_DONE;
      S_DIV:   if (div_last) state_d = S_DONE;
      S_DONE:  if (!stall_ext) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flushE) state_d = S_IDLE;
  end

  // FSM outputs
  always_comb begin
    stall_md = ~flushE & (start | (state_q == S_MUL) | (state_q == S_DIV));
    busy     = (state_q != S_IDLE);
  end

  // Operand latch, iteration counter and multiply/divide accumulator
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_div_d = is_div_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d    = 5'd0;
          acc_d    = {32'h0, a_mag};
          b_d      = b_mag;
          is_div_d = is_div_op;
          // A divide by zero returns all-ones in LO, so its quotient sign fix is suppressed.
          q_neg_d  = is_signed_op & (srcaE[31] ^ srcbE[31]) & ~div0;
          r_neg_d  = is_signed_op & is_div_op & srcaE[31];
`ifdef MULDIV_DIV0_FAST_EN
          if (div0) acc_d = {a_mag, 32'hFFFF_FFFF};
`endif
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 5'd1;
        if (mul_last) acc_d = {32'h0, acc_q[31:0]} * {32'h0, b_q};
      end
      S_DIV: begin
        cnt_d = cnt_q + 5'd1;
        // acc holds {remainder, dividend/quotient}. Each step shifts in one quotient bit.
        if (div_diff[32]) acc_d = {acc_q[62:0], 1'b0};
        else              acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
      end
      default: ;
    endcase
  end

  // Sign-corrected results, applied only at commit
  always_comb begin
    mul_res = q_neg_q ? -acc_q : acc_q;
    div_lo  = q_neg_q ? -acc_q[31:0]  : acc_q[31:0];
    div_hi  = r_neg_q ? -acc_q[63:32] : acc_q[63:32];
  end

  assign commit = (state_q == S_DONE) & ~stall_ext & ~flushE;
  assign mt_ok  = validE & ~flushE & ~stall_ext & (state_q == S_IDLE);

  // HI/LO update: a mul/div commit, or an MTHI/MTLO write while idle
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = is_div_q ? div_hi : mul_res[63:32];
      lo_d = is_div_q ? div_lo : mul_res[31:0];
    end else if (mt_ok) begin
      if (alucontrolE == EXE_MTHI_OP) hi_d = srcaE;
      if (alucontrolE == EXE_MTLO_OP) lo_d = srcaE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= 5'd0;
      acc_q    <= 64'h0;
      b_q      <= 32'h0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= HILO_RST;
      lo_q     <= HILO_RST;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl
//   Self-checking bench for muldiv_ctrl. It runs a table of known vectors,
//   hand-written flush / external-stall / MT* / reset sequences, and random
//   operations checked against an arithmetic reference model.

module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;
`ifdef MULDIV_DIV0_FAST_EN
  localparam int DIV0_STALL = 1;
`else
  localparam int DIV0_STALL = 33;
`endif

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic        clk;
  logic        resetn;
  logic [7:0]  alucontrolE;
  logic        validE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stall_ext;
  logic        stall_md;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;

  int errors = 0;
  int checks = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .HILO_RST(32'h0)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .alucontrolE (alucontrolE),
    .validE      (validE),
    .srcaE       (srcaE),
    .srcbE       (srcbE),
    .flushE      (flushE),
    .stall_ext   (stall_ext),
    .stall_md    (stall_md),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference results computed directly from the arithmetic definition of each op
  function automatic void refModel(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output int stall);
    longint sa, sb, q, r, p;
    hi = 32'h0;
    lo = 32'h0;
    stall = 0;
    case (op)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32]; lo = p[31:0]; stall = MUL_LAT + 1;
      end
      OP_MULTU: begin
        p = longint'({32'h0, a}) * longint'({32'h0, b});
        hi = p[63:32]; lo = p[31:0]; stall = MUL_LAT + 1;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'h0) begin
          lo = 32'hFFFF_FFFF; hi = a; stall = DIV0_STALL;
        end else begin
          if (op == OP_DIV) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
          end else begin
            sa = longint'({32'h0, a}); sb = longint'({32'h0, b});
          end
          q = sa / sb;
          r = sa % sb;
          lo = q[31:0]; hi = r[31:0]; stall = 33;
        end
      end
      default: ;
    endcase
  endfunction

  // Issues one mul/div in EX and holds it there while stall_md is high.
  // hold_ext cycles of stall_ext are then applied in DONE before the
  // instruction is allowed to leave. Results are sampled one cycle later.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int hold_ext, output int stall_cnt,
                               output logic [31:0] hi_r, output logic [31:0] lo_r);
    logic [31:0] hi_prev, lo_prev;
    @(negedge clk);
    hi_prev     = hi_o;
    lo_prev     = lo_o;
    alucontrolE = op;
    srcaE       = a;
    srcbE       = b;
    validE      = 1'b1;
    flushE      = 1'b0;
    stall_ext   = 1'b0;
    stall_cnt   = 0;
    #1;
    while (stall_md && stall_cnt < 200) begin
      stall_cnt++;
      @(negedge clk);
      #1;
    end
    checkOutput("done_busy", 64'(busy), 64'd1);
    checkOutput("done_hi_held", 64'(hi_o), 64'(hi_prev));
    checkOutput("done_lo_held", 64'(lo_o), 64'(lo_prev));
    if (hold_ext > 0) begin
      stall_ext = 1'b1;
      for (int i = 0; i < hold_ext; i++) begin
        checkOutput("ext_stall_md", 64'(stall_md), 64'd0);
        checkOutput("ext_busy", 64'(busy), 64'd1);
        checkOutput("ext_hi_held", 64'(hi_o), 64'(hi_prev));
        @(negedge clk);
        #1;
      end
      stall_ext = 1'b0;
    end
    @(negedge clk);
    validE      = 1'b0;
    alucontrolE = OP_NOP;
    #1;
    checkOutput("after_busy", 64'(busy), 64'd0);
    hi_r = hi_o;
    lo_r = lo_o;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    vec_t        vecs[9];
    int          st;
    logic [31:0] h, l, eh, el;
    int          es;

    vecs[0] = '{OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         33};
    vecs[1] = '{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  33};
    vecs[2] = '{OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  33};
    vecs[3] = '{OP_MULT,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  3};
    vecs[4] = '{OP_MULTU, 32'hFFFF_FFFF,  32'd2,          32'd1,          32'hFFFF_FFFE,  3};
    vecs[5] = '{OP_DIVU,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  DIV0_STALL};
    vecs[6] = '{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
    vecs[7] = '{OP_DIV,   32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFF0,  32'hFFFF_FFFF,  DIV0_STALL};
    vecs[8] = '{OP_DIVU,  32'd9,          32'd3,          32'd0,          32'd3,          33};

    resetn = 1'b0; alucontrolE = OP_NOP; validE = 1'b0; srcaE = '0; srcbE = '0;
    flushE = 1'b0; stall_ext = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_hi", 64'(hi_o), 64'h0);
    checkOutput("reset_lo", 64'(lo_o), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_stall", 64'(stall_md), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 0, st, h, l);
      checkOutput($sformatf("vec%0d_stall", i), 64'(st), 64'(vecs[i].stall));
      checkOutput($sformatf("vec%0d_hi", i), 64'(h), 64'(vecs[i].hi));
      checkOutput($sformatf("vec%0d_lo", i), 64'(l), 64'(vecs[i].lo));
    end

    $display("[TB] MTHI/MTLO");
    @(negedge clk);
    alucontrolE = OP_MTHI; srcaE = 32'h1234_5678; validE = 1'b1;
    #1;
    checkOutput("mthi_stall", 64'(stall_md), 64'd0);
    @(negedge clk);
    alucontrolE = OP_MTLO; srcaE = 32'hCAFE_F00D;
    #1;
    checkOutput("mthi_hi", 64'(hi_o), 64'h1234_5678);
    @(negedge clk);
    alucontrolE = OP_MTHI; srcaE = 32'hDEAD_BEEF; stall_ext = 1'b1;
    #1;
    checkOutput("mtlo_lo", 64'(lo_o), 64'hCAFE_F00D);
    @(negedge clk);
    validE = 1'b0; stall_ext = 1'b0; alucontrolE = OP_NOP;
    #1;
    checkOutput("mthi_ext_blocked", 64'(hi_o), 64'h1234_5678);

    $display("[TB] flush mid-divide");
    @(negedge clk);
    alucontrolE = OP_DIV; srcaE = 32'd1000; srcbE = 32'd3; validE = 1'b1;
    repeat (10) @(negedge clk);
    flushE = 1'b1;
    #1;
    checkOutput("flush_busy_before", 64'(busy), 64'd1);
    checkOutput("flush_stall", 64'(stall_md), 64'd0);
    @(negedge clk);
    flushE = 1'b0; validE = 1'b0; alucontrolE = OP_NOP;
    #1;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    checkOutput("flush_hi", 64'(hi_o), 64'h1234_5678);
    checkOutput("flush_lo", 64'(lo_o), 64'hCAFE_F00D);
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 0, st, h, l);
    checkOutput("post_flush_stall", 64'(st), 64'd33);
    checkOutput("post_flush_hi", 64'(h), 64'd0);
    checkOutput("post_flush_lo", 64'(l), 64'd3);

    $display("[TB] stall_ext held in DONE");
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 5, st, h, l);
    checkOutput("ext_stall_cnt", 64'(st), 64'd33);
    checkOutput("ext_hi", 64'(h), 64'd2);
    checkOutput("ext_lo", 64'(l), 64'd14);

    $display("[TB] random operations");
    for (int i = 0; i < 40; i++) begin
      logic [7:0]  op;
      logic [31:0] a, b;
      int          hold;
      case ($urandom_range(3))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        default: op = OP_DIVU;
      endcase
      a = $urandom;
      case ($urandom_range(5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(15));
        default: b = $urandom;
      endcase
      if ($urandom_range(7) == 0) a = 32'h8000_0000;
      hold = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
      refModel(op, a, b, eh, el, es);
      applyStimulus(op, a, b, hold, st, h, l);
      checkOutput($sformatf("rnd%0d_op%0h_stall", i, op), 64'(st), 64'(es));
      checkOutput($sformatf("rnd%0d_op%0h_a%0h_b%0h_hi", i, op, a, b), 64'(h), 64'(eh));
      checkOutput($sformatf("rnd%0d_op%0h_a%0h_b%0h_lo", i, op, a, b), 64'(l), 64'(el));
    end

    $display("[TB] reset mid-divide");
    @(negedge clk);
    alucontrolE = OP_DIV; srcaE = 32'd77; srcbE = 32'd5; validE = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    validE = 1'b0; alucontrolE = OP_NOP;
    resetn = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_hi", 64'(hi_o), 64'h0);
    checkOutput("midreset_lo", 64'(lo_o), 64'h0);
    checkOutput("midreset_stall", 64'(stall_md), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(OP_MULTU, 32'd6, 32'd7, 0, st, h, l);
    checkOutput("post_reset_stall", 64'(st), 64'(MUL_LAT + 1));
    checkOutput("post_reset_lo", 64'(l), 64'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
